// File: rtl/ws2812_pixel_rx.sv
// WS2812 single-wire pixel receiver. It decodes bits by high-pulse width, skips a number
// of leading pixels, captures a fixed number of pixels and forwards the rest of the frame on DOUT.
module ws2812_pixel_rx #(
  parameter int BITS_PER_PIXEL  = 24,
  parameter int MIN_HIGH_CYCLES = 4,
  parameter int SAMPLE_CYCLES   = 24,
  parameter int MAX_HIGH_CYCLES = 80,
  parameter int RESET_CYCLES    = 200,
  parameter int PIXEL_CAPTURE   = 16,
  parameter int IDX_W           = 11
) (
  input  logic                      CLK_40,
  input  logic                      reset,
  input  logic                      DIN,
  input  logic [IDX_W-1:0]          skip_pixels,
  output logic                      DOUT,
  output logic [BITS_PER_PIXEL-1:0] pixel_data,
  output logic [IDX_W-1:0]          pixel_index,
  output logic                      pixel_valid,
  output logic                      frame_sync,
  output logic                      bit_error,
  output logic                      passthru
);

  localparam int HW = $clog2(MAX_HIGH_CYCLES + 1);
  localparam int LW = $clog2(RESET_CYCLES + 1);
  localparam int BW = $clog2(BITS_PER_PIXEL + 1);

  localparam logic [HW-1:0]    HighOne    = HW'(1);
  localparam logic [HW-1:0]    HighMin    = HW'(MIN_HIGH_CYCLES);
  localparam logic [HW-1:0]    HighSample = HW'(SAMPLE_CYCLES);
  localparam logic [HW-1:0]    HighMax    = HW'(MAX_HIGH_CYCLES);
  localparam logic [LW-1:0]    LowOne     = LW'(1);
  localparam logic [LW-1:0]    LowMax     = LW'(RESET_CYCLES);
  localparam logic [BW-1:0]    BitLast    = BW'(BITS_PER_PIXEL - 1);
  localparam logic [IDX_W-1:0] CapLast    = IDX_W'(PIXEL_CAPTURE - 1);

  typedef enum logic [1:0] {WAIT_RESET, IDLE, RX, PASS} state_e;

  state_e state_q, state_d;

  logic dinMeta_q, dinSync_q, dinHist_q;
  logic rise, fall;
  logic [HW-1:0] highCnt_q, highCnt_d;
  logic [LW-1:0] lowCnt_q, lowCnt_d;
  logic highHit, lowHit;

  logic [IDX_W-1:0]          skip_q, skip_d;
  logic [IDX_W-1:0]          pixCnt_q, pixCnt_d;
  logic [IDX_W-1:0]          capCnt_q, capCnt_d;
  logic [BW-1:0]             bitCnt_q, bitCnt_d;
  logic [BITS_PER_PIXEL-1:0] shift_q, shift_d;
  logic                      pixDone_q, pixDone_d;
  logic [BITS_PER_PIXEL-1:0] data_q, data_d;
  logic [IDX_W-1:0]          index_q, index_d;
  logic                      valid_q, valid_d;
  logic                      fsync_q, fsync_d;
  logic                      err_q, err_d;
  logic                      keepPixel, lastCapture;

  // Synchroniser and history flop carry no reset; WAIT_RESET masks any start-up garbage.
  always_ff @(posedge CLK_40) begin
    dinMeta_q <= DIN;
    dinSync_q <= dinMeta_q;
    dinHist_q <= dinSync_q;
  end

  assign rise = dinSync_q & ~dinHist_q;
  assign fall = ~dinSync_q & dinHist_q;

  always_comb begin
    highCnt_d = highCnt_q;
    lowCnt_d  = lowCnt_q;
    if (rise)
      highCnt_d = HighOne;
    else if (dinSync_q && highCnt_q != HighMax)
      highCnt_d = highCnt_q + 1'b1;
    if (fall)
      lowCnt_d = LowOne;
    else if (!dinSync_q && lowCnt_q != LowMax)
      lowCnt_d = lowCnt_q + 1'b1;
  end

  // Each hit fires only on the cycle the counter first reaches saturation.
  assign highHit = (highCnt_d == HighMax) && (highCnt_q != HighMax);
  assign lowHit  = (lowCnt_d == LowMax) && (lowCnt_q != LowMax);

  assign keepPixel   = pixCnt_q >= skip_q;
  assign lastCapture = capCnt_q == CapLast;

  always_ff @(posedge CLK_40) begin
    if (reset) state_q <= WAIT_RESET;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WAIT_RESET: if (lowHit) state_d = IDLE;
      IDLE:       if (rise) state_d = RX;
      RX: begin
        if (highHit)                                   state_d = WAIT_RESET;
        else if (lowHit)                               state_d = IDLE;
        else if (pixDone_q && keepPixel && lastCapture) state_d = PASS;
      end
      PASS:       if (lowHit) state_d = IDLE;
      default:    state_d = WAIT_RESET;
    endcase
  end

  always_comb begin
    skip_d    = skip_q;
    pixCnt_d  = pixCnt_q;
    capCnt_d  = capCnt_q;
    bitCnt_d  = bitCnt_q;
    shift_d   = shift_q;
    pixDone_d = 1'b0;
    data_d    = data_q;
    index_d   = index_q;
    valid_d   = 1'b0;
    fsync_d   = 1'b0;
    err_d     = 1'b0;
    unique case (state_q)
      WAIT_RESET: fsync_d = lowHit;
      IDLE: begin
        if (rise) begin
          skip_d   = skip_pixels;
          pixCnt_d = '0;
          capCnt_d = '0;
          bitCnt_d = '0;
        end
      end
      RX: begin
        if (highHit) begin
          err_d    = 1'b1;
          bitCnt_d = '0;
        end else if (lowHit) begin
          fsync_d  = 1'b1;
          err_d    = bitCnt_q != '0;
          bitCnt_d = '0;
        end else begin
          if (fall) begin
            if (highCnt_q < HighMin) begin
              err_d = 1'b1;
            end else begin
              shift_d = {shift_q[BITS_PER_PIXEL-2:0], highCnt_q >= HighSample};
              if (bitCnt_q == BitLast) begin
                bitCnt_d  = '0;
                pixDone_d = 1'b1;
              end else begin
                bitCnt_d = bitCnt_q + 1'b1;
              end
            end
          end
          // Completed pixel is judged one cycle after its last bit lands in shift_q.
          if (pixDone_q) begin
            if (keepPixel) begin
              data_d   = shift_q;
              index_d  = capCnt_q;
              valid_d  = 1'b1;
              capCnt_d = capCnt_q + 1'b1;
            end
            if (pixCnt_q != '1)
              pixCnt_d = pixCnt_q + 1'b1;
          end
        end
      end
      PASS:    fsync_d = lowHit;
      default: ;
    endcase
  end

  always_ff @(posedge CLK_40) begin
    if (reset) begin
      highCnt_q <= '0;
      lowCnt_q  <= '0;
      skip_q    <= '0;
      pixCnt_q  <= '0;
      capCnt_q  <= '0;
      bitCnt_q  <= '0;
      shift_q   <= '0;
      pixDone_q <= 1'b0;
      data_q    <= '0;
      index_q   <= '0;
      valid_q   <= 1'b0;
      fsync_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      highCnt_q <= highCnt_d;
      lowCnt_q  <= lowCnt_d;
      skip_q    <= skip_d;
      pixCnt_q  <= pixCnt_d;
      capCnt_q  <= capCnt_d;
      bitCnt_q  <= bitCnt_d;
      shift_q   <= shift_d;
      pixDone_q <= pixDone_d;
      data_q    <= data_d;
      index_q   <= index_d;
      valid_q   <= valid_d;
      fsync_q   <= fsync_d;
      err_q     <= err_d;
    end
  end

  assign passthru    = state_q == PASS;
  assign DOUT        = passthru & dinSync_q;
  assign pixel_data  = data_q;
  assign pixel_index = index_q;
  assign pixel_valid = valid_q;
  assign frame_sync  = fsync_q;
  assign bit_error   = err_q;

endmodule
